pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and generates the EX-stage forwarding selects. It sequences variable-latency data-memory accesses in the MEM stage through a req/ready handshake with a wait-timeout watchdog. Two saturating performance counters track lost cycles.

## Interface
- TIMEOUT, 255: maximum consecutive MEM wait cycles before the error state is entered (1..2^CNT_W-1).
- CNT_W, 16: width of the wait counter and of each performance counter.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Rs1D, Rs2D  in  5  source registers in ID.
- Rs1E, Rs2E, RdE  in  5  source and destination registers in EX.
- RdM, RdW  in  5  destination registers in MEM and WB.
- RegWriteM, RegWriteW  in  1  register write-enable in MEM and WB.
- ResultSrcE0  in  1  EX instruction is a load.
- PCSrcE  in  1  taken branch or jump resolved in EX.
- MemReqM  in  1  MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request.
- ForwardAE, ForwardBE  out  2  EX operand selects: 00 register file, 01 WB result, 10 MEM ALU result.
- StallF, StallD, StallE, StallM  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1  load a bubble into IF/ID, ID/EX and MEM/WB.
- mem_err  out  1  sticky timeout error.
- lw_stall_cnt, mem_wait_cnt  out  CNT_W  performance counters.

## Operation
- Forwarding, ForwardAE (ForwardBE is identical using Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00.
  - MEM takes priority over WB.
- lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states:
  - IDLE to WAIT when MemReqM && !dmem_ready; the wait counter is loaded with 1.
  - WAIT to IDLE when dmem_ready.
  - WAIT: when dmem_ready is low and wait counter == TIMEOUT, go to ERROR. Otherwise the counter increments.
  - ERROR is terminal until reset.
- memStall = (state!=ERROR) && MemReqM && !dmem_ready.
- dmem_req = MemReqM && state!=ERROR. Once asserted, it stays high until the edge on which dmem_ready is high. An access completes on each edge with dmem_req && dmem_ready.
- Control priority, highest first:
  - ERROR: StallF/D/E/M = 1, all flushes = 0, mem_err = 1.
  - memStall: StallF/D/E/M = 1, FlushW = 1, FlushD = FlushE = 0. A branch in EX is held and its flush takes effect in the first cycle after the stall releases.
  - Otherwise: StallF = StallD = lwStall, FlushE = lwStall || PCSrcE, FlushD = PCSrcE, StallE = StallM = FlushW = 0.
- Counters saturate at 2^CNT_W-1:
  - lw_stall_cnt increments on each cycle with lwStall && !memStall && state!=ERROR.
  - mem_wait_cnt increments on each memStall cycle.

## Timing
- Forwarding, stall, flush and dmem_req outputs are combinational from the inputs and the registered state. They must be valid before the clock edge that updates the pipeline registers.
- The state, wait counter, mem_err and performance counters update on the rising clk edge.
- Reset, asynchronous and usable mid-operation:
  - state = IDLE, wait counter = 0, mem_err = 0, both performance counters = 0.
  - With all inputs low, every combinational output is 0.
- Latency:
  - A zero-wait memory (dmem_ready high in the request cycle) causes no stall.
  - N wait cycles cause exactly N stall cycles.
  - A load-use hazard costs exactly 1 cycle.
- Back-to-back memory instructions: the FSM returns to IDLE on completion, and the next MEM instruction requests in the following cycle with no idle gap.
- dmem_ready while MemReqM is low is ignored.

## Structure
- Package pipe_ctrl_pkg holds:
  - The state enum: IDLE, WAIT, ERROR.
  - Forwarding constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module sat_counter (parameter W; inputs clk, reset, inc; output count). It is instantiated twice, once per performance counter.

## Test plan
- RAW forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=10. Same case with RdM=0 → 01. All write-enables low → 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle; lw_stall_cnt goes 0→1. With RdE=0 → no stall.
- Memory wait: MemReqM=1, dmem_ready low for 3 cycles then high → StallF/D/E/M and FlushW high for exactly 3 cycles, mem_wait_cnt=3, FSM ends in IDLE.
- Branch during memStall: PCSrcE=1 while waiting → FlushD/FlushE stay 0 until ready, then both are 1 in the next cycle.
- Timeout: TIMEOUT=4, dmem_ready never asserted → ERROR entered on the 5th edge. From then mem_err=1, dmem_req=0 and all stalls are 1. Asserting reset clears everything to IDLE/0.
- Saturation: CNT_W=4 with 20 consecutive wait cycles → mem_wait_cnt holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

   // MEM-stage access sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ERROR = 2'd2
   } state_t;

   // EX operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Pick the freshest producer of a source register; x0 is never forwarded.
   // MEM is younger than WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       wr_m,
                                          input logic [4:0] rd_w,
                                          input logic       wr_w);
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the lost-cycle performance counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count events, holding at all-ones instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipeline:
// forwarding selects, load-use and memory-wait stalls, branch flushes,
// MEM-stage request sequencing with a timeout watchdog, and lost-cycle counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             mem_err,
   output logic [CNT_W-1:0] lw_stall_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             lw_stall;
   logic             mem_stall;
   logic             in_error;

   // Operand forwarding into EX
   always_comb begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
   end

   // Hazard detection; the error state suppresses memory stalls and requests
   always_comb begin
      in_error  = (state == ERROR);
      lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
      mem_stall = !in_error && MemReqM && !dmem_ready;
      dmem_req  = MemReqM && !in_error;
   end

   // Stall/flush priority: error freeze, then memory wait, then load-use/branch.
   // While waiting on memory a taken branch in EX is held by StallE, so its
   // flush simply appears once the stall releases.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (in_error) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushE = lw_stall || PCSrcE;
         FlushD = PCSrcE;
      end
   end

   // MEM access sequencer with wait-timeout watchdog; ERROR holds until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (MemReqM && !dmem_ready) begin
                  state    <= WAIT;
                  wait_cnt <= CNT_W'(1);
               end
            end
            WAIT: begin
               if (dmem_ready) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else if (wait_cnt == TIMEOUT_C) begin
                  state   <= ERROR;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            ERROR: begin
               mem_err <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_lw_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (lw_stall && !mem_stall && !in_error),
      .count (lw_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_mem_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mem_stall),
      .count (mem_wait_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: three instances share one set of
// inputs (default, short timeout, narrow counters); stimulus queues expected
// values per cycle and a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, dmem_ready;

   // main instance (TIMEOUT 255, CNT_W 16)
   logic        m_req, m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_fw, m_err;
   logic [1:0]  m_fa, m_fb;
   logic [15:0] m_lw, m_mw;
   // short timeout instance (TIMEOUT 4)
   logic        t_req, t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_fw, t_err;
   logic [1:0]  t_fa, t_fb;
   logic [15:0] t_lw, t_mw;
   // narrow counter instance (CNT_W 4, TIMEOUT 15)
   logic        s_req, s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw, s_err;
   logic [1:0]  s_fa, s_fb;
   logic [3:0]  s_lw, s_mw;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.TIMEOUT(255), .CNT_W(16)) dut_m (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
      .dmem_req(m_req), .ForwardAE(m_fa), .ForwardBE(m_fb),
      .StallF(m_sf), .StallD(m_sd), .StallE(m_se), .StallM(m_sm),
      .FlushD(m_fd), .FlushE(m_fe), .FlushW(m_fw), .mem_err(m_err),
      .lw_stall_cnt(m_lw), .mem_wait_cnt(m_mw));

   pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut_t (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
      .dmem_req(t_req), .ForwardAE(t_fa), .ForwardBE(t_fb),
      .StallF(t_sf), .StallD(t_sd), .StallE(t_se), .StallM(t_sm),
      .FlushD(t_fd), .FlushE(t_fe), .FlushW(t_fw), .mem_err(t_err),
      .lw_stall_cnt(t_lw), .mem_wait_cnt(t_mw));

   pipeline_hazard_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
      .dmem_req(s_req), .ForwardAE(s_fa), .ForwardBE(s_fb),
      .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .StallM(s_sm),
      .FlushD(s_fd), .FlushE(s_fe), .FlushW(s_fw), .mem_err(s_err),
      .lw_stall_cnt(s_lw), .mem_wait_cnt(s_mw));

   localparam int M_FWD   = 0;   // {ForwardAE, ForwardBE}
   localparam int M_STALL = 1;   // {StallF, StallD, StallE, StallM}
   localparam int M_FLUSH = 2;   // {FlushD, FlushE, FlushW}
   localparam int M_REQ   = 3;
   localparam int M_ERR   = 4;
   localparam int M_LW    = 5;
   localparam int M_MW    = 6;
   localparam int T_STALL = 7;
   localparam int T_FLUSH = 8;
   localparam int T_REQ   = 9;
   localparam int T_ERR   = 10;
   localparam int S_MW    = 11;
   localparam int S_ERR   = 12;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] act;
   int          cyc    = 0;
   int          n_cmp  = 0;
   int          n_bad  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         M_FWD:   return {28'd0, m_fa, m_fb};
         M_STALL: return {28'd0, m_sf, m_sd, m_se, m_sm};
         M_FLUSH: return {29'd0, m_fd, m_fe, m_fw};
         M_REQ:   return {31'd0, m_req};
         M_ERR:   return {31'd0, m_err};
         M_LW:    return {16'd0, m_lw};
         M_MW:    return {16'd0, m_mw};
         T_STALL: return {28'd0, t_sf, t_sd, t_se, t_sm};
         T_FLUSH: return {29'd0, t_fd, t_fe, t_fw};
         T_REQ:   return {31'd0, t_req};
         T_ERR:   return {31'd0, t_err};
         S_MW:    return {28'd0, s_mw};
         S_ERR:   return {31'd0, s_err};
         default: return 32'hdead_beef;
      endcase
   endfunction

   // Monitor: compare every expectation queued for the current cycle
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e   = sb.pop_front();
         act = get_sig(e.sel);
         n_cmp++;
         if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", e.name, e.cyc, act, e.exp);
         end
      end
   end

   task automatic ck(input int sel, input logic [31:0] v, input string nm);
      exp_t x;
      x.cyc  = cyc;
      x.sel  = sel;
      x.exp  = v;
      x.name = nm;
      sb.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
      RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
      RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
      PCSrcE = 1'b0; MemReqM = 1'b0; dmem_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      zero_inputs();

      // Reset state: all outputs zero
      step();
      ck(M_FWD, 0, "rst_fwd");     ck(M_STALL, 0, "rst_stall");
      ck(M_FLUSH, 0, "rst_flush"); ck(M_REQ, 0, "rst_req");
      ck(M_ERR, 0, "rst_err");     ck(M_LW, 0, "rst_lw");
      ck(M_MW, 0, "rst_mw");       ck(T_ERR, 0, "rst_t_err");
      ck(S_MW, 0, "rst_s_mw");
      step();
      reset = 1'b0;

      // Forwarding
      step();
      Rs1E = 5'd5; Rs2E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
      ck(M_FWD, 32'b1010, "fwd_mem_prio");
      step();
      RdM = 5'd0;
      ck(M_FWD, 32'b0101, "fwd_wb");
      step();
      RdM = 5'd5; RegWriteM = 1'b0; RegWriteW = 1'b0;
      ck(M_FWD, 32'b0000, "fwd_rf");
      step();
      RegWriteM = 1'b1; RegWriteW = 1'b1; RdW = 5'd9; Rs1E = 5'd9;
      ck(M_FWD, 32'b0110, "fwd_mixed");
      step();
      RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
      ck(M_FWD, 32'b0000, "fwd_x0");

      // Load-use
      step();
      zero_inputs(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
      ck(M_STALL, 32'b1100, "lu_stall"); ck(M_FLUSH, 32'b010, "lu_flush");
      ck(M_LW, 0, "lu_cnt_before");
      step();
      zero_inputs();
      ck(M_STALL, 0, "lu_release"); ck(M_FLUSH, 0, "lu_release_flush");
      ck(M_LW, 1, "lu_cnt_after");
      step();
      ResultSrcE0 = 1'b1; RdE = 5'd0;
      ck(M_STALL, 0, "lu_x0_stall"); ck(M_FLUSH, 0, "lu_x0_flush");
      step();
      zero_inputs();
      ck(M_LW, 1, "lu_x0_cnt");

      // Branch alone
      step();
      PCSrcE = 1'b1;
      ck(M_FLUSH, 32'b110, "br_flush"); ck(M_STALL, 0, "br_stall");

      // Memory wait of 3 cycles with a branch arriving during the wait
      step();
      zero_inputs(); MemReqM = 1'b1; dmem_ready = 1'b0;
      ck(M_STALL, 32'hF, "mw1_stall"); ck(M_FLUSH, 32'b001, "mw1_flush");
      ck(M_REQ, 1, "mw1_req"); ck(M_MW, 0, "mw1_cnt");
      step();
      ck(M_STALL, 32'hF, "mw2_stall"); ck(M_MW, 1, "mw2_cnt");
      step();
      PCSrcE = 1'b1;
      ck(M_STALL, 32'hF, "mw3_stall"); ck(M_FLUSH, 32'b001, "mw3_br_held");
      ck(M_MW, 2, "mw3_cnt");
      step();
      dmem_ready = 1'b1;
      ck(M_STALL, 0, "mw_done_stall"); ck(M_FLUSH, 32'b110, "mw_done_br_flush");
      ck(M_REQ, 1, "mw_done_req"); ck(M_MW, 3, "mw_done_cnt");

      // Back-to-back accesses
      step();
      PCSrcE = 1'b0;
      ck(M_STALL, 0, "b2b_zero_wait"); ck(M_FLUSH, 0, "b2b_flush"); ck(M_REQ, 1, "b2b_req");
      step();
      dmem_ready = 1'b0;
      ck(M_STALL, 32'hF, "b2b_wait_stall"); ck(M_REQ, 1, "b2b_wait_req");
      step();
      dmem_ready = 1'b1;
      ck(M_STALL, 0, "b2b_done"); ck(M_MW, 4, "b2b_cnt");

      // dmem_ready without a request is ignored
      step();
      MemReqM = 1'b0;
      ck(M_REQ, 0, "idle_ready_req"); ck(M_STALL, 0, "idle_ready_stall");
      ck(M_FLUSH, 0, "idle_ready_flush");
      step();
      dmem_ready = 1'b0;
      ck(M_MW, 4, "idle_ready_cnt"); ck(M_STALL, 0, "idle_after");

      // Load-use hidden under a memory wait is not counted
      step();
      zero_inputs(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7; MemReqM = 1'b1;
      ck(M_STALL, 32'hF, "lu_mw_stall"); ck(M_FLUSH, 32'b001, "lu_mw_flush");
      ck(M_LW, 1, "lu_mw_cnt");
      step();
      dmem_ready = 1'b1;
      ck(M_STALL, 32'b1100, "lu_after_mw_stall"); ck(M_FLUSH, 32'b010, "lu_after_mw_flush");
      ck(M_LW, 1, "lu_after_mw_cnt"); ck(M_MW, 5, "lu_after_mw_mw");
      step();
      zero_inputs();
      ck(M_LW, 2, "lu_final_cnt"); ck(M_MW, 5, "mw_final_cnt");
      ck(M_ERR, 0, "no_err"); ck(T_ERR, 0, "t_no_err");

      // Timeout and saturation: request never completes
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         MemReqM = 1'b1; dmem_ready = 1'b0;
         ck(T_STALL, 32'hF, $sformatf("to_stall_%0d", k));
         if (k <= 5) begin
            ck(T_REQ, 1, $sformatf("to_req_%0d", k));
            ck(T_ERR, 0, $sformatf("to_err_%0d", k));
            ck(T_FLUSH, 32'b001, $sformatf("to_flush_%0d", k));
         end else begin
            ck(T_REQ, 0, $sformatf("to_req_%0d", k));
            ck(T_ERR, 1, $sformatf("to_err_%0d", k));
            ck(T_FLUSH, 0, $sformatf("to_flush_%0d", k));
         end
         if (k == 15) ck(S_MW, 14, "sat_14");
         if (k >= 16) ck(S_MW, 15, $sformatf("sat_hold_%0d", k));
         if (k == 16) ck(S_ERR, 0, "sat_err_pre");
         if (k >= 17) ck(S_ERR, 1, $sformatf("sat_err_%0d", k));
         if (k == 20) begin
            ck(M_MW, 19, "m_long_wait_cnt");
            ck(M_ERR, 0, "m_long_wait_err");
            ck(M_STALL, 32'hF, "m_long_wait_stall");
         end
      end

      // Asynchronous reset mid-operation
      step();
      zero_inputs();
      reset = 1'b1;
      ck(T_ERR, 0, "arst_t_err"); ck(T_REQ, 0, "arst_t_req");
      ck(T_STALL, 0, "arst_t_stall"); ck(T_FLUSH, 0, "arst_t_flush");
      ck(S_MW, 0, "arst_s_mw"); ck(S_ERR, 0, "arst_s_err");
      ck(M_MW, 0, "arst_m_mw"); ck(M_LW, 0, "arst_m_lw");
      step();
      reset = 1'b0; MemReqM = 1'b1;
      ck(T_REQ, 1, "post_rst_req"); ck(T_STALL, 32'hF, "post_rst_stall");
      ck(T_ERR, 0, "post_rst_err");
      step();
      zero_inputs();

      // Drain the scoreboard with a bounded wait
      for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
